// File: rtl/sseg_xn_ctrl.sv
// N-digit multiplexed 7-segment controller for common-anode displays:
// refresh prescaler, leading-zero blanking, decimal points, PWM dimming, lamp test.
module sseg_xn_ctrl #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 100000,
    parameter int DUTY_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_blank,
    input  logic [DUTY_W-1:0]     brightness,
    input  logic                  test,
    output logic [6:0]            sseg_ca,
    output logic                  sseg_dp,
    output logic [DIGITS-1:0]     sseg_an,
    output logic                  slot_tick
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DUTY_W-1:0] pwm_q, pwm_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        ca_q, ca_d;
    logic              dp_q, dp_d;

    logic [DIGITS-1:0] blank;
    logic [3:0]        cur_bcd;
    logic              pwm_on;
    logic              zero_run;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign slot_tick = (presc_q == PW'(CLK_DIV - 1));
    assign pwm_on    = (pwm_q <= brightness);
    assign cur_bcd   = bcd[4*idx_q +: 4];

    // Walk from the most significant digit down; a digit is a leading zero
    // only while every digit above it is zero too. Digit 0 always shows.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (bcd[4*i +: 4] == 4'h0);
            blank[i] = lz_blank && (i > 0) && zero_run && !dp[i];
        end
    end

    always_comb begin
        presc_d = slot_tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (slot_tick)
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        pwm_d   = pwm_q + 1'b1;

        // Anodes and cathodes share one register stage, so a slot change
        // never shows the old pattern on the new digit.
        an_d = '1;
        ca_d = 7'h7F;
        dp_d = 1'b1;
        if (test) begin
            an_d = '0;
            ca_d = 7'h00;
            dp_d = 1'b0;
        end else if (!blank[idx_q] && pwm_on) begin
            an_d[idx_q] = 1'b0;
            ca_d        = decode(cur_bcd);
            dp_d        = ~dp[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            pwm_q   <= '0;
            an_q    <= '1;
            ca_q    <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_d;
            an_q    <= an_d;
            ca_q    <= ca_d;
            dp_q    <= dp_d;
        end
    end

    assign sseg_an = an_q;
    assign sseg_ca = ca_q;
    assign sseg_dp = dp_q;

endmodule
